// File: rtl/usb_pkt_fifo.sv
// Packet-aware FIFO between the SIE and the CPU register file: tentative writes
// become readable on commit, and reads can be rewound to the last release point.
module usb_pkt_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 64,
   parameter bit AUTO_COMMIT = 1'b0,
   parameter int AF_LEVEL    = DEPTH - 4,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             push_i,
   input  logic             wr_commit_i,
   input  logic             wr_abort_i,
   output logic [WIDTH-1:0] data_o,
   input  logic             pop_i,
   output logic             data_valid_o,
   input  logic             rd_release_i,
   input  logic             rd_rewind_i,
   output logic [AW:0]      level_o,
   output logic [AW:0]      free_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             almost_full_o,
   output logic             overflow_o,
   output logic             underflow_o
);

   localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_P    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] ONE     = (AW+1)'(1);

   logic [WIDTH-1:0] ram [DEPTH];

   logic [AW:0] wr_ptr, wr_cmt, rd_ptr, rd_mk;
   logic [AW:0] wr_ptr_nxt, rd_ptr_nxt, used;
   logic        abort_eff, commit_eff, rewind_eff, release_eff;
   logic        push_ok, pop_ok;

   // Handshake: push_i/pop_i are single-cycle requests with no ready signal; a
   // request is taken when space/data exist, otherwise it only raises the sticky
   // overflow/underflow flag. Abort/rewind silence a same-cycle push/pop entirely.
   assign abort_eff   = !AUTO_COMMIT && wr_abort_i;
   assign commit_eff  = !AUTO_COMMIT && wr_commit_i && !wr_abort_i;
   assign rewind_eff  = !AUTO_COMMIT && rd_rewind_i;
   assign release_eff = !AUTO_COMMIT && rd_release_i && !rd_rewind_i;

   assign level_o = wr_cmt - rd_ptr;
   assign used    = wr_ptr - rd_mk;
   assign free_o  = DEPTH_P - used;

   assign empty_o       = (level_o == '0);
   assign full_o        = (free_o == '0);
   assign almost_full_o = (used >= AF_P);

   assign push_ok = push_i && !full_o && !abort_eff;
   assign pop_ok  = pop_i && !empty_o && !rewind_eff;

   assign wr_ptr_nxt = push_ok ? wr_ptr + ONE : wr_ptr;
   assign rd_ptr_nxt = pop_ok ? rd_ptr + ONE : rd_ptr;

   // Storage is never cleared; pointers alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok && !rst_i && !flush_i)
         ram[wr_ptr[AW-1:0]] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr       <= '0;
         wr_cmt       <= '0;
         rd_ptr       <= '0;
         rd_mk        <= '0;
         data_o       <= '0;
         data_valid_o <= 1'b0;
         overflow_o   <= 1'b0;
         underflow_o  <= 1'b0;
      end else begin
         wr_ptr <= abort_eff ? wr_cmt : wr_ptr_nxt;
         if (AUTO_COMMIT || commit_eff)
            wr_cmt <= wr_ptr_nxt;
         // Space freed by a pop reaches the writer only once the read is released.
         rd_ptr <= rewind_eff ? rd_mk : rd_ptr_nxt;
         if (AUTO_COMMIT || release_eff)
            rd_mk <= rd_ptr_nxt;
         data_valid_o <= pop_ok;
         if (pop_ok)
            data_o <= ram[rd_ptr[AW-1:0]];
         if (push_i && full_o && !abort_eff)
            overflow_o <= 1'b1;
         if (pop_i && empty_o && !rewind_eff)
            underflow_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// Directed bench for usb_pkt_fifo: one AUTO_COMMIT=1 and one AUTO_COMMIT=0
// instance (DEPTH=8) share the input stimulus; each section checks one of them.
module tb_usb_pkt_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [7:0] din = '0;
   logic       push = 1'b0, commit = 1'b0, abort = 1'b0;
   logic       pop = 1'b0, rel = 1'b0, rewind = 1'b0;

   logic [7:0] a_data, p_data;
   logic [3:0] a_level, a_free, p_level, p_free;
   logic       a_dv, a_empty, a_full, a_af, a_ovf, a_unf;
   logic       p_dv, p_empty, p_full, p_af, p_ovf, p_unf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   usb_pkt_fifo #(.WIDTH(8), .DEPTH(8), .AUTO_COMMIT(1'b1)) u_auto (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .push_i(push),
      .wr_commit_i(commit), .wr_abort_i(abort), .data_o(a_data), .pop_i(pop),
      .data_valid_o(a_dv), .rd_release_i(rel), .rd_rewind_i(rewind),
      .level_o(a_level), .free_o(a_free), .empty_o(a_empty), .full_o(a_full),
      .almost_full_o(a_af), .overflow_o(a_ovf), .underflow_o(a_unf));

   usb_pkt_fifo #(.WIDTH(8), .DEPTH(8), .AUTO_COMMIT(1'b0)) u_pkt (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .push_i(push),
      .wr_commit_i(commit), .wr_abort_i(abort), .data_o(p_data), .pop_i(pop),
      .data_valid_o(p_dv), .rd_release_i(rel), .rd_rewind_i(rewind),
      .level_o(p_level), .free_o(p_free), .empty_o(p_empty), .full_o(p_full),
      .almost_full_o(p_af), .overflow_o(p_ovf), .underflow_o(p_unf));

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // One clock with the given inputs; outputs are stable when this returns.
   task automatic step(input logic ps, input logic [7:0] d, input logic pp,
                       input logic cm, input logic ab, input logic rl, input logic rw);
      push = ps; din = d; pop = pp; commit = cm; abort = ab; rel = rl; rewind = rw;
      @(posedge clk);
      #1;
      push = 0; pop = 0; commit = 0; abort = 0; rel = 0; rewind = 0; flush = 0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step(0, 8'h00, 0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_level", int'(a_level), 0);
      check("rst_free", int'(a_free), 8);
      check("rst_empty", int'(a_empty), 1);
      check("rst_full", int'(a_full), 0);
      check("rst_data", int'(a_data), 0);
      check("rst_dv", int'(a_dv), 0);
      check("rst_flags", int'({a_ovf, a_unf, p_ovf, p_unf}), 0);

      // Plain FIFO behaviour with AUTO_COMMIT=1
      for (int i = 0; i < 8; i++) step(1, 8'(8'h11 + i), 0, 0, 0, 0, 0);
      check("auto_full", int'(a_full), 1);
      check("auto_free0", int'(a_free), 0);
      check("auto_level8", int'(a_level), 8);
      check("auto_af", int'(a_af), 1);
      check("auto_ovf_pre", int'(a_ovf), 0);
      step(1, 8'h99, 0, 0, 0, 0, 0);
      check("auto_ovf", int'(a_ovf), 1);
      check("auto_level_ovf", int'(a_level), 8);
      for (int i = 0; i < 8; i++) begin
         step(0, 8'h00, 1, 0, 0, 0, 0);
         check("auto_pop_dv", int'(a_dv), 1);
         check("auto_pop_data", int'(a_data), 8'h11 + i);
      end
      check("auto_free_back", int'(a_free), 8);
      check("auto_unf_pre", int'(a_unf), 0);
      step(0, 8'h00, 1, 0, 0, 0, 0);
      check("auto_unf", int'(a_unf), 1);
      check("auto_unf_dv", int'(a_dv), 0);
      check("auto_data_hold", int'(a_data), 8'h18);

      // Abort then commit
      do_flush();
      check("flush_auto_unf", int'(a_unf), 0);
      step(1, 8'h01, 0, 0, 0, 0, 0);
      step(1, 8'h02, 0, 0, 0, 0, 0);
      step(1, 8'h03, 0, 0, 0, 0, 0);
      check("tent_level", int'(p_level), 0);
      check("tent_free", int'(p_free), 5);
      step(0, 8'h00, 0, 0, 1, 0, 0);
      check("abort_level", int'(p_level), 0);
      check("abort_free", int'(p_free), 8);
      step(1, 8'hA0, 0, 0, 0, 0, 0);
      step(1, 8'hA1, 0, 1, 0, 0, 0);
      check("commit_level", int'(p_level), 2);
      check("commit_free", int'(p_free), 6);
      step(0, 8'h00, 1, 0, 0, 0, 0);
      check("pop_a0", int'(p_data), 8'hA0);
      check("pop_a0_dv", int'(p_dv), 1);
      check("pop_nofree", int'(p_free), 6);

      // Rewind and release
      do_flush();
      for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, (i == 3), 0, 0, 0);
      check("pkt4_level", int'(p_level), 4);
      for (int i = 0; i < 3; i++) begin
         step(0, 8'h00, 1, 0, 0, 0, 0);
         check("pkt4_pop", int'(p_data), 8'h40 + i);
      end
      check("pre_rewind_level", int'(p_level), 1);
      step(0, 8'h00, 0, 0, 0, 0, 1);
      check("rewind_level", int'(p_level), 4);
      step(0, 8'h00, 1, 0, 0, 0, 0);
      check("rewind_pop", int'(p_data), 8'h40);
      step(0, 8'h00, 1, 0, 0, 1, 0);
      check("release_data", int'(p_data), 8'h41);
      check("release_free", int'(p_free), 6);
      check("release_level", int'(p_level), 2);

      // Same-cycle priority
      step(1, 8'h55, 0, 1, 1, 0, 0);
      check("abort_wins_level", int'(p_level), 2);
      check("abort_wins_free", int'(p_free), 6);
      check("abort_no_ovf", int'(p_ovf), 0);
      step(0, 8'h00, 1, 0, 0, 0, 0);
      check("pop_42", int'(p_data), 8'h42);
      step(0, 8'h00, 1, 0, 0, 1, 1);
      check("rewind_pop_dv", int'(p_dv), 0);
      check("rewind_wins_level", int'(p_level), 2);
      check("rewind_wins_free", int'(p_free), 6);
      do_flush();
      step(0, 8'h00, 1, 0, 0, 0, 1);
      check("rewind_no_unf", int'(p_unf), 0);
      check("rewind_empty_dv", int'(p_dv), 0);
      step(0, 8'h00, 1, 0, 0, 0, 0);
      check("empty_pop_unf", int'(p_unf), 1);

      // Pointer wrap over many packets
      do_flush();
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 5; k++) step(1, 8'(r * 16 + k + 1), 0, (k == 4), 0, 0, 0);
         check("wrap_level", int'(p_level), 5);
         check("wrap_free", int'(p_free), 3);
         for (int k = 0; k < 5; k++) begin
            step(0, 8'h00, 1, 0, 0, (k == 4), 0);
            check("wrap_data", int'(p_data), r * 16 + k + 1);
         end
         check("wrap_level0", int'(p_level), 0);
         check("wrap_free8", int'(p_free), 8);
      end

      // Flush mid-packet, with a push in the flush cycle
      do_flush();
      for (int i = 0; i < 3; i++) step(1, 8'(8'h61 + i), 0, (i == 2), 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 8'(8'h64 + i), 0, 0, 0, 0, 0);
      check("mid_full", int'(p_full), 1);
      check("mid_af", int'(p_af), 1);
      step(1, 8'h77, 0, 0, 0, 0, 0);
      check("mid_ovf", int'(p_ovf), 1);
      check("mid_level", int'(p_level), 3);
      flush = 1'b1;
      step(1, 8'hEE, 1, 0, 0, 0, 0);
      check("flush_level", int'(p_level), 0);
      check("flush_free", int'(p_free), 8);
      check("flush_empty", int'(p_empty), 1);
      check("flush_ovf", int'(p_ovf), 0);
      check("flush_dv", int'(p_dv), 0);

      // Same scenario cleared by reset
      for (int i = 0; i < 3; i++) step(1, 8'(8'h61 + i), 0, (i == 2), 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 8'(8'h64 + i), 0, 0, 0, 0, 0);
      check("rst_pre_ovf", int'(p_ovf), 1);
      step(0, 8'h00, 1, 0, 0, 0, 0);
      check("rst_pre_data", int'(p_data), 8'h61);
      rst = 1'b1;
      step(1, 8'hEE, 1, 0, 0, 0, 0);
      rst = 1'b0;
      check("reset_data", int'(p_data), 0);
      check("reset_level", int'(p_level), 0);
      check("reset_free", int'(p_free), 8);
      check("reset_empty", int'(p_empty), 1);
      check("reset_ovf", int'(p_ovf), 0);
      check("reset_dv", int'(p_dv), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
